uart_tx_model: RTL and testbench

Testbench UART transmitter that sits directly upstream of the co-simulation UART receive/log path, or of the DUT's UART RX pin. It accepts bytes from the bench through a write handshake and buffers them in a small FIFO. It serializes them as standard asynchronous 8N1-style frames on `uart_txd`. Bench tasks can queue a whole text line, for example `"A\n"`, without waiting for each frame to finish.

---
 rtl/uart_tx_model.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_model.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_model.sv
// uart_tx_model: FIFO-buffered asynchronous serial transmitter for bench use.
// Bytes are queued through a write strobe, then sent as start/data/stop frames
// LSB first. Each bit is held for CLK_HZ/BIT_RATE clocks.
module uart_tx_model #(
   parameter int BIT_RATE     = 9600,
   parameter int CLK_HZ       = 50_000_000,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic                             wr_en,
   input  logic [7:0]                       wr_data,
   input  logic                             uart_tx_en,
   output logic                             uart_txd,
   output logic                             uart_tx_busy,
   output logic                             fifo_full,
   output logic                             fifo_empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
   output logic                             overflow
);

   localparam int CPB   = CLK_HZ / BIT_RATE;
   localparam int CNT_W = $clog2(CPB);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int IDX_W = 3;

   localparam logic [CNT_W-1:0] LAST_CYC  = CNT_W'(CPB - 1);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(PAYLOAD_BITS - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
   localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cyc_q, cyc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [7:0]         shift_q, shift_d;
   logic               txd_q, txd_d;
   logic               busy_q, busy_d;

   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               full_q, empty_q, ovf_q;

   logic               push, pop, can_launch;
   logic [7:0]         head;

   // A write is accepted only if the FIFO was not full before the edge;
   // a pop on the same edge does not make room for it.
   assign push       = wr_en && !full_q;
   assign can_launch = uart_tx_en && !empty_q;
   assign head       = mem_q[rd_ptr_q];
   assign level_d    = level_q + LVL_W'(push) - LVL_W'(pop);

   // Serializer FSM: next state, bit-cycle/bit-index counters, shift register and txd.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned and no latch is inferred.
      state_d = state_q;
      cyc_d   = cyc_q + CNT_W'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            cyc_d = '0;
            idx_d = '0;
            if (can_launch) begin
               pop     = 1'b1;
               shift_d = head;
               state_d = START;
            end
         end
         START: begin
            if (cyc_q == LAST_CYC) begin
               state_d = DATA;
               cyc_d   = '0;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (cyc_q == LAST_CYC) begin
               cyc_d = '0;
               if (idx_q == LAST_DATA) begin
                  state_d = STOP;
                  idx_d   = '0;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  shift_d = shift_q >> 1;
               end
            end
         end
         STOP: begin
            if (cyc_q == LAST_CYC) begin
               cyc_d = '0;
               if (idx_q == LAST_STOP) begin
                  idx_d = '0;
                  // Chain straight into the next frame when data is waiting.
                  if (can_launch) begin
                     pop     = 1'b1;
                     shift_d = head;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            cyc_d   = '0;
            idx_d   = '0;
         end
      endcase

      // txd and busy are decoded from the next state so the flops present them
      // in the same cycle the state is entered.
      txd_d = 1'b1;
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   // FSM state, counters, shift register and registered serial outputs.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!resetn) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
      end
   end

   // FIFO pointers, level counter, registered flags and sticky overflow.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         level_q <= level_d;
         full_q  <= (level_d == DEPTH_LVL);
         empty_q <= (level_d == '0);
         if (wr_en && full_q) ovf_q <= 1'b1;
      end
   end

   // FIFO storage; contents are meaningless until written.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; the level counter alone says which entries are valid.
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign uart_txd     = txd_q;
   assign uart_tx_busy = busy_q;
   assign fifo_full    = full_q;
   assign fifo_empty   = empty_q;
   assign fifo_level   = level_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_uart_tx_model.sv
// tb_uart_tx_model: directed and randomized checks of uart_tx_model against a
// queue-based byte model and an arithmetic per-cycle frame waveform model.
`timescale 1ns/1ps
module tb_uart_tx_model;

   localparam int CLK_HZ       = 50_000_000;
   localparam int BIT_RATE     = 5_000_000;
   localparam int CPB          = CLK_HZ / BIT_RATE;
   localparam int PAYLOAD_BITS = 8;
   localparam int STOP_BITS    = 1;
   localparam int FIFO_DEPTH   = 16;
   localparam int FRAME        = (1 + PAYLOAD_BITS + STOP_BITS) * CPB;
   localparam int LVL_W        = $clog2(FIFO_DEPTH + 1);

   typedef logic [7:0] byte_t;
   typedef byte_t byte_q_t [$];

   logic             clk = 1'b0;
   logic             resetn = 1'b1;
   logic             wr_en = 1'b0;
   logic [7:0]       wr_data = 8'h00;
   logic             uart_tx_en = 1'b0;
   logic             uart_txd;
   logic             uart_tx_busy;
   logic             fifo_full;
   logic             fifo_empty;
   logic [LVL_W-1:0] fifo_level;
   logic             overflow;

   int    checks = 0;
   int    errors = 0;
   byte_t model_q [$];   // bytes accepted but not yet seen on the line
   byte_t sent_q  [$];   // every accepted byte, in order
   byte_t rx_q    [$];   // bytes decoded from the line
   bit    ovf_exp = 1'b0;

   uart_tx_model #(
      .BIT_RATE     (BIT_RATE),
      .CLK_HZ       (CLK_HZ),
      .PAYLOAD_BITS (PAYLOAD_BITS),
      .STOP_BITS    (STOP_BITS),
      .FIFO_DEPTH   (FIFO_DEPTH)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .uart_tx_en   (uart_tx_en),
      .uart_txd     (uart_txd),
      .uart_tx_busy (uart_tx_busy),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .fifo_level   (fifo_level),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line level for every clock of a frame carrying byte b.
   function automatic logic [127:0] exp_frame(input byte_t b);
      logic [127:0] v = '0;
      for (int c = 0; c < FRAME; c++) begin
         int p = c / CPB;
         if (p == 0)                 v[c] = 1'b0;
         else if (p <= PAYLOAD_BITS) v[c] = (b >> (p - 1)) & 8'h01;
         else                        v[c] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [127:0] frame_ones();
      logic [127:0] v = '0;
      for (int c = 0; c < FRAME; c++) v[c] = 1'b1;
      return v;
   endfunction

   // Line monitor: finds start bits, checks each frame cycle by cycle against
   // the next expected byte, and decodes the byte at bit centres.
   initial begin : monitor
      logic [127:0] obs_v, bsy_v;
      byte_t        b, d;
      bit           aborted;
      bit           after_frame = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            after_frame = 1'b0;
            continue;
         end
         if (after_frame && uart_txd === 1'b1) check("busy_drop_after_frame", uart_tx_busy, 1'b0);
         after_frame = 1'b0;
         if (uart_txd !== 1'b0) continue;
         check("frame_expected", int'(model_q.size() > 0), 1);
         b = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
         obs_v   = '0;
         bsy_v   = '0;
         aborted = 1'b0;
         for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if (!resetn) begin
               aborted = 1'b1;
               break;
            end
            obs_v[c] = uart_txd;
            bsy_v[c] = uart_tx_busy;
         end
         if (!aborted) begin
            check("frame_txd", obs_v, exp_frame(b));
            check("frame_busy", bsy_v, frame_ones());
            for (int i = 0; i < 8; i++) d[i] = obs_v[CPB * (1 + i) + CPB / 2];
            rx_q.push_back(d);
            after_frame = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      resetn = 1'b0;
      model_q.delete();
      sent_q.delete();
      rx_q.delete();
      ovf_exp = 1'b0;
      repeat (3) @(negedge clk);
      #1 resetn = 1'b1;
   endtask

   task automatic write_burst(input byte_q_t bytes);
      foreach (bytes[i]) begin
         @(negedge clk); #1;
         wr_en   = 1'b1;
         wr_data = bytes[i];
         if (model_q.size() < FIFO_DEPTH) begin
            model_q.push_back(bytes[i]);
            sent_q.push_back(bytes[i]);
         end else begin
            ovf_exp = 1'b1;
         end
      end
      @(negedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n    = 0;
      bit done = 1'b0;
      while (n < budget) begin
         @(negedge clk); #1;
         n++;
         if (!uart_tx_busy && fifo_empty && model_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      check({tag, "_idle_reached"}, done, 1'b1);
      @(negedge clk); #1;
   endtask

   task automatic check_rx(input string tag);
      check({tag, "_rx_count"}, rx_q.size(), sent_q.size());
      foreach (sent_q[i]) begin
         if (i < rx_q.size()) check({tag, "_rx_byte"}, rx_q[i], sent_q[i]);
      end
   endtask

   task automatic busy_run(output int n);
      n = 0;
      while (uart_tx_busy === 1'b1 && n < 1000) begin
         n++;
         @(negedge clk); #1;
      end
   endtask

   initial begin : stimulus
      byte_q_t bq;
      int      n;
      bit      ok;
      string   line;

      // ---- Reset values (asynchronous) ----
      #1 resetn = 1'b0;
      #1;
      check("rst_txd", uart_txd, 1'b1);
      check("rst_busy", uart_tx_busy, 1'b0);
      check("rst_full", fifo_full, 1'b0);
      check("rst_empty", fifo_empty, 1'b1);
      check("rst_level", fifo_level, 0);
      check("rst_overflow", overflow, 1'b0);
      do_reset();

      // ---- Single frame 0x55 with write-to-start latency ----
      uart_tx_en = 1'b1;
      bq = '{8'h55};
      write_burst(bq);
      check("single_level_k", fifo_level, 1);
      check("single_empty_k", fifo_empty, 1'b0);
      check("single_txd_k", uart_txd, 1'b1);
      check("single_busy_k", uart_tx_busy, 1'b0);
      @(negedge clk); #1;
      check("single_txd_k1", uart_txd, 1'b0);
      check("single_busy_k1", uart_tx_busy, 1'b1);
      check("single_level_k1", fifo_level, 0);
      busy_run(n);
      check("single_busy_len", n, FRAME);
      wait_idle("single", 300);
      check_rx("single");

      // ---- Randomized bytes with random gaps ----
      rx_q.delete();
      sent_q.delete();
      for (int i = 0; i < 8; i++) begin
         bq = '{byte_t'($urandom)};
         write_burst(bq);
         repeat ($urandom_range(0, 150)) @(negedge clk);
      end
      wait_idle("random", 2000);
      check_rx("random");

      // ---- Loopback "A\n": contiguous frames, logged line ----
      rx_q.delete();
      sent_q.delete();
      bq = '{8'h41, 8'h0A};
      write_burst(bq);
      busy_run(n);
      check("loop_busy_len", n, 2 * FRAME);
      wait_idle("loop", 400);
      check_rx("loop");
      line = "";
      foreach (rx_q[i]) if (rx_q[i] != 8'h0A) line = $sformatf("%s%c", line, rx_q[i]);
      $display("uart log line: \"%s\"", line);
      check("loop_line", int'(line == "A"), 1);

      // ---- Overflow: 17 writes into a 16-deep FIFO while disabled ----
      do_reset();
      uart_tx_en = 1'b0;
      bq = {};
      for (int i = 0; i <= 16; i++) bq.push_back(byte_t'(i));
      write_burst(bq);
      check("ovf_full", fifo_full, 1'b1);
      check("ovf_level", fifo_level, model_q.size());
      check("ovf_flag", overflow, ovf_exp);
      check("ovf_sent_count", sent_q.size(), FIFO_DEPTH);
      uart_tx_en = 1'b1;
      wait_idle("ovf", 20 * FRAME);
      check_rx("ovf");
      check("ovf_empty_after", fifo_empty, 1'b1);
      check("ovf_sticky", overflow, 1'b1);

      // ---- Pause: drop enable during DATA of frame 1 ----
      do_reset();
      uart_tx_en = 1'b1;
      bq = '{byte_t'($urandom), byte_t'($urandom), byte_t'($urandom)};
      write_burst(bq);
      n = 0;
      while (uart_txd !== 1'b0 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      check("pause_start_seen", uart_txd, 1'b0);
      repeat (30) @(negedge clk);
      #1 uart_tx_en = 1'b0;
      repeat (FRAME) @(negedge clk);
      ok = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) ok = 1'b0;
      end
      check("pause_line_idle", ok, 1'b1);
      check("pause_level", fifo_level, 2);
      check("pause_rx_count", rx_q.size(), 1);
      uart_tx_en = 1'b1;
      wait_idle("pause", 5 * FRAME);
      check_rx("pause");

      // ---- Simultaneous push and pop while full ----
      do_reset();
      uart_tx_en = 1'b0;
      bq = {};
      for (int i = 0; i < FIFO_DEPTH; i++) bq.push_back(byte_t'($urandom));
      write_burst(bq);
      check("simul_full_before", fifo_full, 1'b1);
      @(negedge clk); #1;
      uart_tx_en = 1'b1;
      wr_en      = 1'b1;
      wr_data    = 8'hAA;
      if (model_q.size() < FIFO_DEPTH) begin
         model_q.push_back(8'hAA);
         sent_q.push_back(8'hAA);
      end else begin
         ovf_exp = 1'b1;
      end
      @(negedge clk); #1;
      wr_en = 1'b0;
      check("simul_level", fifo_level, FIFO_DEPTH - 1);
      check("simul_overflow", overflow, ovf_exp);
      check("simul_full_after", fifo_full, 1'b0);
      wait_idle("simul", 20 * FRAME);
      check_rx("simul");

      // ---- Reset mid-frame while txd is low ----
      do_reset();
      uart_tx_en = 1'b1;
      bq = '{8'h00};
      write_burst(bq);
      repeat (40) @(negedge clk);
      #1;
      check("midrst_txd_low", uart_txd, 1'b0);
      #2 resetn = 1'b0;
      #1;
      check("midrst_txd", uart_txd, 1'b1);
      check("midrst_busy", uart_tx_busy, 1'b0);
      check("midrst_full", fifo_full, 1'b0);
      check("midrst_empty", fifo_empty, 1'b1);
      check("midrst_level", fifo_level, 0);
      check("midrst_overflow", overflow, 1'b0);
      model_q.delete();
      sent_q.delete();
      rx_q.delete();
      repeat (3) @(negedge clk);
      #1 resetn = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (uart_txd !== 1'b1 || uart_tx_busy !== 1'b0) ok = 1'b0;
      end
      check("midrst_quiet", ok, 1'b1);
      check("midrst_rx_none", rx_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
